// File: rtl/rca_wb_sequencer.sv
// RCA writeback sequencer: buffers RCA completions and serialises their results onto the single register-file write port.
// Optional feature: define RCA_WB_BYPASS_EN for a zero-latency first write when the FIFO is empty.

package rca_wb_pkg;
    typedef logic [3:0] id_t;
endpackage

module rca_wb_sequencer #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned NUM_WRITE_PORTS = 2,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned ID_W            = $bits(rca_wb_pkg::id_t)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wb_done,
    input  logic [ID_W-1:0]                       wb_id,
    input  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]  wb_rd,
    input  logic [NUM_WRITE_PORTS-1:0][4:0]       wb_dest_addr,
    input  logic [NUM_WRITE_PORTS-1:0]            wb_dest_valid,
    output logic                                  rf_we,
    output logic [4:0]                            rf_addr,
    output logic [XLEN-1:0]                       rf_data,
    input  logic                                  rf_ack,
    output logic                                  instr_done,
    output logic [ID_W-1:0]                       instr_done_id,
    output logic                                  wb_stall,
    output logic                                  overflow
);

    localparam int unsigned NP     = NUM_WRITE_PORTS;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned PORT_W = (NP > 1) ? $clog2(NP) : 1;

    typedef enum logic {
        S_IDLE,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    // FIFO storage; pending mask of the head entry is cleared in place as writes are acked
    logic [ID_W-1:0]          id_mem   [FIFO_DEPTH];
    logic [NP-1:0][XLEN-1:0]  rd_mem   [FIFO_DEPTH];
    logic [NP-1:0][4:0]       addr_mem [FIFO_DEPTH];
    logic [NP-1:0]            pend_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic                    full, push_req, push, pop, drop, ack_head, bypass_retire;
    logic [NP-1:0]           in_pend, push_pend;
    logic [NP-1:0]           head_pend, head_bit, head_rem;
    logic [PORT_W-1:0]       head_port;
    logic [NP-1:0][XLEN-1:0] head_rd;
    logic [NP-1:0][4:0]      head_addr;

    function automatic logic [PORT_W-1:0] lowest_port(input logic [NP-1:0] m);
        lowest_port = '0;
        for (int i = int'(NP) - 1; i >= 0; i--) begin
            if (m[i]) lowest_port = PORT_W'(i);
        end
    endfunction

    // Writes to x0 are never issued, so they never enter the pending mask
    always_comb begin
        in_pend = '0;
        for (int i = 0; i < int'(NP); i++) begin
            in_pend[i] = wb_dest_valid[i] && (wb_dest_addr[i] != 5'd0);
        end
    end

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign head_pend = pend_mem[rd_ptr_q];
    assign head_rd   = rd_mem[rd_ptr_q];
    assign head_addr = addr_mem[rd_ptr_q];
    assign head_port = lowest_port(head_pend);
    assign head_bit  = NP'(1) << head_port;

`ifdef RCA_WB_BYPASS_EN
    logic [PORT_W-1:0] in_port;
    logic [NP-1:0]     in_bit;

    assign in_port = lowest_port(in_pend);
    assign in_bit  = NP'(1) << in_port;
`endif

    // Next-state, write-port and retire decode
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        rf_we         = 1'b0;
        rf_addr       = 5'd0;
        rf_data       = '0;
        instr_done    = 1'b0;
        instr_done_id = '0;
        ack_head      = 1'b0;
        pop           = 1'b0;
        push_pend     = in_pend;
        bypass_retire = 1'b0;
        head_rem      = head_pend;

        case (state_q)
            S_IDLE: begin
`ifdef RCA_WB_BYPASS_EN
                if (wb_done) begin
                    if (in_pend != '0) begin
                        rf_we   = 1'b1;
                        rf_addr = wb_dest_addr[in_port];
                        rf_data = wb_rd[in_port];
                        if (rf_ack) push_pend = in_pend & ~in_bit;
                    end
                    if (push_pend == '0) begin
                        instr_done    = 1'b1;
                        instr_done_id = wb_id;
                        bypass_retire = 1'b1;
                    end
                end
`endif
            end
            S_DRAIN: begin
                if (head_pend != '0) begin
                    rf_we    = 1'b1;
                    rf_addr  = head_addr[head_port];
                    rf_data  = head_rd[head_port];
                    ack_head = rf_ack;
                end
                head_rem = ack_head ? (head_pend & ~head_bit) : head_pend;
                // Retire in the cycle the last write is accepted (or at once for an empty mask)
                if (head_rem == '0) begin
                    instr_done    = 1'b1;
                    instr_done_id = id_mem[rd_ptr_q];
                    pop           = 1'b1;
                end
            end
            default: ;
        endcase

        push_req = wb_done && !bypass_retire;
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        state_d = (count_d != '0) ? S_DRAIN : S_IDLE;

        // An in-flight entry discarded by reset never reports completion
        if (rst) begin
            instr_done    = 1'b0;
            instr_done_id = '0;
        end
    end

    // Control state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wb_stall <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wb_stall <= (count_d >= CNT_W'(FIFO_DEPTH - 1));
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    // Entry storage; a push into the slot being popped (full + pop) takes priority
    always_ff @(posedge clk) begin
        if (ack_head) pend_mem[rd_ptr_q] <= head_rem;
        if (push) begin
            id_mem[wr_ptr_q]   <= wb_id;
            rd_mem[wr_ptr_q]   <= wb_rd;
            addr_mem[wr_ptr_q] <= wb_dest_addr;
            pend_mem[wr_ptr_q] <= push_pend;
        end
    end

endmodule
